// File: rtl/row_scan_if.sv
// row_scan_if: control/config inputs and decoder-facing outputs of the row-scan controller.
interface row_scan_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               one_shot;
    logic [4:0]         num_rows;
    logic [DWELL_W-1:0] dwell;
    logic [4:0]         sel;
    logic               sel_en;
    logic               row_strobe;
    logic               frame_done;
    logic               busy;
    modport master (
        output start, stop, one_shot, num_rows, dwell,
        input  sel, sel_en, row_strobe, frame_done, busy
    );
    modport slave (
        input  start, stop, one_shot, num_rows, dwell,
        output sel, sel_en, row_strobe, frame_done, busy
    );
endinterface

// File: rtl/row_scan_ctrl.sv
// row_scan_ctrl: steps a 5-to-24 decoder through rows 0..N-1 with programmable dwell
// and a fixed break-before-make blank gap between rows.
module row_scan_ctrl #(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    row_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);
    state_t             state_q;
    logic [4:0]         sel_q, last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dcnt_q, dwell_d;
    logic [3:0]         bcnt_q;
    logic               one_shot_q, stop_pend_q, sel_en_q, row_strobe_q, frame_done_q, busy_q;
    logic               at_last;
    // configuration is stored pre-decremented so the counters can run down to zero
    assign last_d  = (bus.num_rows == 5'd0 || bus.num_rows > 5'd24) ? 5'd23 : bus.num_rows - 5'd1;
    assign dwell_d = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
    assign at_last = sel_q == last_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_q       <= '0;
            dwell_q      <= '0;
            dcnt_q       <= '0;
            bcnt_q       <= '0;
            one_shot_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            sel_en_q     <= 1'b0;
            row_strobe_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            row_strobe_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        last_q       <= last_d;
                        dwell_q      <= dwell_d;
                        one_shot_q   <= bus.one_shot;
                        dcnt_q       <= dwell_d;
                        sel_q        <= '0;
                        sel_en_q     <= 1'b1;
                        row_strobe_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    stop_pend_q <= stop_pend_q | bus.stop;
                    if (dcnt_q == '0) begin
                        sel_en_q     <= 1'b0;
                        bcnt_q       <= BLANK_LAST;
                        frame_done_q <= (BLANK_LAST == 4'd0) && at_last;
                        state_q      <= BLANK;
                    end else begin
                        dcnt_q <= dcnt_q - DWELL_W'(1);
                    end
                end
                BLANK: begin
                    if (bcnt_q != 4'd0) begin
                        stop_pend_q  <= stop_pend_q | bus.stop;
                        bcnt_q       <= bcnt_q - 4'd1;
                        frame_done_q <= (bcnt_q == 4'd1) && at_last;
                    end else if (stop_pend_q || bus.stop || (at_last && one_shot_q)) begin
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        // sel only moves on the edge that re-enables the decoder
                        sel_q        <= at_last ? 5'd0 : sel_q + 5'd1;
                        dcnt_q       <= dwell_q;
                        sel_en_q     <= 1'b1;
                        row_strobe_q <= 1'b1;
                        state_q      <= ACTIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.sel        = sel_q;
    assign bus.sel_en     = sel_en_q;
    assign bus.row_strobe = row_strobe_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/row_scan_ctrl.md
# row_scan_ctrl

Sequential row-scan controller that drives the 5-bit index and enable of the 5-to-24 one-hot decoder, stepping through rows 0..N-1 with a programmable per-row dwell and a fixed break-before-make blank gap. It sits directly upstream of the decoder: `sel` feeds the decoder's `x` and `sel_en` feeds its `en`. It supports continuous scanning or single-frame operation, with a clean stop at a row boundary.

## Interface
- `DWELL_W`, 16: width of the dwell count.
- `BLANK_CYCLES`, 2: cycles with `sel_en`=0 between rows. Legal range 1..15.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin scanning. Sampled only in IDLE.
- `stop` in 1: request stop at the end of the current row. Sampled only while busy.
- `one_shot` in 1: latched at start. 1 = single frame, 0 = continuous.
- `num_rows` in 5: rows per frame, latched at start. 0 or >24 is clamped to 24.
- `dwell` in DWELL_W: enabled cycles per row, latched at start. 0 is treated as 1.
- `sel` out 5: row index to the decoder, registered.
- `sel_en` out 1: decoder enable, registered.
- `row_strobe` out 1: one-cycle pulse on the first enabled cycle of each row.
- `frame_done` out 1: one-cycle pulse on the last blank cycle of row N-1.
- `busy` out 1: high in ACTIVE and BLANK.

## Operation
- **States:** IDLE, ACTIVE, BLANK.
- **Internal registers:** latched `num_rows`, `dwell` and `one_shot`, a dwell counter, a blank counter and a `stop_pend` flag.
- **IDLE:**
  - `start`=1 and `stop`=0: latch the configuration, set `sel`=0 and go to ACTIVE.
  - `start` and `stop` both high in IDLE: stay IDLE.
- **ACTIVE:**
  - `sel_en`=1 for exactly `dwell` cycles.
  - `row_strobe`=1 on the first of those cycles.
  - Then go to BLANK.
- **BLANK:**
  - `sel_en`=0 and `sel` holds for BLANK_CYCLES cycles.
  - On the last blank cycle, the next state is chosen as follows:
    - `stop_pend` set: go to IDLE.
    - `sel`=N-1 and `one_shot`=1: go to IDLE.
    - `sel`=N-1 and `one_shot`=0: set `sel`=0 and go to ACTIVE.
    - Otherwise: set `sel`=`sel`+1 and go to ACTIVE.
  - `frame_done`=1 on that last blank cycle whenever `sel`=N-1, regardless of the exit path.
- **Stop:**
  - `stop`=1 in any busy cycle sets `stop_pend`.
  - The current row completes its full dwell and full blank. The FSM then enters IDLE with `sel` held at the last row value.
  - `stop_pend` clears on entry to IDLE.
- **Ignored inputs:** `start` while busy has no effect. Configuration inputs have no effect after latching.
- **Invariant:** `sel_en`=1 is never asserted with `sel`>23.
- **Wrap:** in continuous mode `sel` wraps from N-1 to 0. It never counts past N-1.
- **Reset:**
  - `sel`=0, `sel_en`=0, `row_strobe`=0, `frame_done`=0, `busy`=0.
  - State returns to IDLE and `stop_pend`=0.
  - Reset mid-row drops `sel_en` on the next edge with no blank phase and no `frame_done`.

## Timing
- `start` is sampled at edge k. From cycle k+1: `busy`=1, `sel_en`=1, `row_strobe`=1, `sel`=0.
- Row period is `dwell`+BLANK_CYCLES cycles.
- Frame period is N·(`dwell`+BLANK_CYCLES) cycles.
- The `sel` change always occurs on the same edge that raises `sel_en`, after at least BLANK_CYCLES cycles of `sel_en`=0. This gives break-before-make at the decoder outputs.
- After the final blank cycle (stop, or end of a one-shot frame), the next cycle has `busy`=0. A new `start` is accepted in that cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst` for 3 cycles mid-ACTIVE -> next cycle `sel_en`=0, `busy`=0, `sel`=0, no `frame_done`.
- **One-shot, small config:** `num_rows`=3, `dwell`=4, BLANK_CYCLES=2, `one_shot`=1, pulse `start` ->
  - `sel` goes 0,1,2, each with 4 enabled cycles then 2 blank cycles.
  - 3 `row_strobe` pulses.
  - `frame_done` at cycle 18 after `start`, then `busy`=0.
- **Clamp and zero dwell:** `num_rows`=0, `dwell`=0, continuous ->
  - 24 rows, each with 1 enabled cycle.
  - `sel` wraps 23 -> 0.
  - `frame_done` every 72 cycles with BLANK_CYCLES=2.
- **Stop mid-row:** `num_rows`=5, `dwell`=10, continuous, `stop` pulsed on the 3rd enabled cycle of row 2 -> row 2 completes 10 enabled cycles and 2 blank cycles, then IDLE with `sel`=2 and no `frame_done`.
- **Simultaneous inputs:** `start` and `stop` high together in IDLE -> remain IDLE. `start` pulsed while busy -> no change in sequence timing.
- **Stop on last row:** `stop` during row N-1 -> `frame_done` still pulses on the last blank cycle, then IDLE.
